// File: rtl/jtpang_vtiming.sv
// Pang video timing: fractional pixel-enable divider, h/v counters,
// registered blank/sync windows, frame-latched flip and vblank interrupt.
module jtpang_vtiming #(
    parameter int CW       = 4,
    parameter int HW       = 9,
    parameter int VW       = 9,
    parameter int HTOTAL   = 512,
    parameter int VTOTAL   = 272,
    parameter int HB_START = 384,
    parameter int HB_END   = 0,
    parameter int HS_START = 416,
    parameter int HS_END   = 448,
    parameter int VB_START = 248,
    parameter int VB_END   = 8,
    parameter int VS_START = 252,
    parameter int VS_END   = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cen_n,
    input  logic [CW-1:0] cen_m,
    input  logic          flip,
    output logic          pxl2_cen,
    output logic          pxl_cen,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic [HW-1:0] hf,
    output logic [VW-1:0] vf,
    output logic          LHBL,
    output logic          LVBL,
    output logic          HS,
    output logic          VS,
    output logic          vint
);

    // [a,b) window, wrapping through zero when a > b
    function automatic logic in_win(input logic [31:0] x, a, b);
        if (a < b) return (x >= a) && (x < b);
        if (a > b) return (x >= a) || (x < b);
        return 1'b0;
    endfunction

    localparam logic LHBL_RST = !in_win(32'd0, HB_START, HB_END);
    localparam logic LVBL_RST = !in_win(32'd0, VB_START, VB_END);
    localparam logic HS_RST   = in_win(32'd0, HS_START, HS_END);
    localparam logic VS_RST   = in_win(32'd0, VS_START, VS_END);

    logic [CW-1:0] acc, acc_nx;
    logic [CW:0]   sum, diff;
    logic          cen, tg;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, cen_n};
        diff   = sum - {1'b0, cen_m};
        cen    = 1'b0;
        acc_nx = sum[CW-1:0];
        if (cen_m == '0) begin
            acc_nx = '0;
        end else if (sum >= {1'b0, cen_m}) begin
            cen    = 1'b1;
            // n >= m would leave acc above m forever; clamp it
            acc_nx = (diff >= {1'b0, cen_m}) ? '0 : diff[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            tg       <= 1'b0;
            pxl2_cen <= 1'b0;
            pxl_cen  <= 1'b0;
        end else begin
            acc      <= acc_nx;
            tg       <= tg ^ cen;
            pxl2_cen <= cen;
            pxl_cen  <= cen & tg;
        end
    end

    logic          h_wrap, v_wrap;
    logic [HW-1:0] h_nx;
    logic [VW-1:0] v_nx;
    logic          hb_nx, hs_nx, vb_nx, vs_nx;

    always_comb begin
        h_wrap = h == HW'(HTOTAL - 1);
        v_wrap = v == VW'(VTOTAL - 1);
        h_nx   = h_wrap ? '0 : h + HW'(1);
        v_nx   = v;
        if (h_wrap) v_nx = v_wrap ? '0 : v + VW'(1);
        hb_nx  = in_win(32'(h_nx), HB_START, HB_END);
        hs_nx  = in_win(32'(h_nx), HS_START, HS_END);
        vb_nx  = in_win(32'(v_nx), VB_START, VB_END);
        vs_nx  = in_win(32'(v_nx), VS_START, VS_END);
    end

    logic flip_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h      <= '0;
            v      <= '0;
            flip_l <= 1'b0;
            LHBL   <= LHBL_RST;
            LVBL   <= LVBL_RST;
            HS     <= HS_RST;
            VS     <= VS_RST;
            vint   <= 1'b0;
        end else begin
            vint <= 1'b0;
            if (pxl_cen) begin
                h    <= h_nx;
                v    <= v_nx;
                LHBL <= !hb_nx;
                HS   <= hs_nx;
                LVBL <= !vb_nx;
                VS   <= vs_nx;
                vint <= LVBL & vb_nx;
                // flip only changes between frames
                if (h_wrap && v_wrap) flip_l <= flip;
            end
        end
    end

    assign hf = h ^ {HW{flip_l}};
    assign vf = v ^ {VW{flip_l}};

endmodule

// File: tb/tb_jtpang_vtiming.sv
// Directed bench for jtpang_vtiming: a default-size instance for the
// divider and line checks, a shrunken-frame instance for frame/flip/vint.
module tb_jtpang_vtiming;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] n = 4'd1, m = 4'd3;
    logic       flip = 1'b0;
    logic       pxl2_cen, pxl_cen, LHBL, LVBL, HS, VS, vint;
    logic [8:0] h, v, hf, vf;

    logic       rst_s = 1'b1;
    logic [3:0] n_s = 4'd4, m_s = 4'd3;
    logic       flip_s = 1'b0;
    logic       pxl2_cen_s, pxl_cen_s, LHBL_s, LVBL_s, HS_s, VS_s, vint_s;
    logic [4:0] h_s, v_s, hf_s, vf_s;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtpang_vtiming u_dut (
        .clk(clk), .rst(rst), .cen_n(n), .cen_m(m), .flip(flip),
        .pxl2_cen(pxl2_cen), .pxl_cen(pxl_cen), .h(h), .v(v),
        .hf(hf), .vf(vf), .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
        .vint(vint)
    );

    // 16x20 frame: HB 12..15, HS 13..14, VB 16..19+0..1, VS 17..18
    jtpang_vtiming #(
        .HW(5), .VW(5), .HTOTAL(16), .VTOTAL(20),
        .HB_START(12), .HB_END(0), .HS_START(13), .HS_END(15),
        .VB_START(16), .VB_END(2), .VS_START(17), .VS_END(19)
    ) u_small (
        .clk(clk), .rst(rst_s), .cen_n(n_s), .cen_m(m_s), .flip(flip_s),
        .pxl2_cen(pxl2_cen_s), .pxl_cen(pxl_cen_s), .h(h_s), .v(v_s),
        .hf(hf_s), .vf(vf_s), .LHBL(LHBL_s), .LVBL(LVBL_s), .HS(HS_s),
        .VS(VS_s), .vint(vint_s)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_default();
        check("rst_pxl2_cen", pxl2_cen, 0);
        check("rst_pxl_cen", pxl_cen, 0);
        check("rst_h", h, 0);
        check("rst_v", v, 0);
        check("rst_hf", hf, 0);
        check("rst_vf", vf, 0);
        check("rst_LHBL", LHBL, 1);
        check("rst_LVBL", LVBL, 0);
        check("rst_HS", HS, 0);
        check("rst_VS", VS, 0);
        check("rst_vint", vint, 0);
    endtask

    // release reset with n=1,m=3 and check edges 1..12
    task automatic first_scenario();
        n = 4'd1;
        m = 4'd3;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("seq_pxl2_cen", pxl2_cen, 32'(k % 3 == 0));
            check("seq_pxl_cen", pxl_cen, 32'(k % 6 == 0));
            if (k == 7) check("seq_h_after_7", h, 1);
        end
    endtask

    int cnt, bad_h, bad_v, bad_lhbl, bad_lvbl, bad_hs, bad_vs;
    int bad_p2, bad_p, bad_hf, bad_vf, bad_vint, vints;
    int p, eh, ev;
    logic       fl;
    logic [4:0] eh5, ev5;

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        check_reset_default();

        // n=1, m=3 startup and long-run rate
        first_scenario();
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cnt += int'(pxl_cen);
        end
        check("rate_pxl_cen_1000", cnt, 166);
        check("rate_h", h, 168);
        check("rate_v", v, 0);

        // acc=2 here; n=2,m=2 takes the clamp path to acc=0
        @(negedge clk);
        check("clamp_pre", pxl2_cen, 0);
        n = 4'd2;
        m = 4'd2;
        @(negedge clk);
        check("clamp_cen", pxl2_cen, 1);
        n = 4'd1;
        m = 4'd3;
        @(negedge clk);
        check("clamp_acc0_a", pxl2_cen, 0);
        @(negedge clk);
        check("clamp_acc0_b", pxl2_cen, 0);
        @(negedge clk);
        check("clamp_acc0_c", pxl2_cen, 1);

        // m=0 freezes everything
        rst = 1'b1;
        @(negedge clk);
        first_scenario();
        @(negedge clk);
        check("stop_h_start", h, 2);
        m = 4'd0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt += int'(pxl2_cen) + int'(pxl_cen);
        end
        check("stop_enables", cnt, 0);
        check("stop_h", h, 2);
        check("stop_v", v, 0);
        check("stop_LHBL", LHBL, 1);

        // n=4,m=3: cen every clk; line sweep
        rst = 1'b1;
        @(negedge clk);
        n = 4'd4;
        m = 4'd3;
        @(negedge clk);
        rst = 1'b0;
        {cnt, bad_h, bad_v, bad_lhbl, bad_lvbl, bad_hs, bad_p2, bad_p} = '0;
        for (int e = 1; e <= 1425; e++) begin
            @(negedge clk);
            p  = (e - 1) / 2;
            eh = p % 512;
            ev = p / 512;
            if (e <= 1024) cnt += int'(pxl_cen);
            bad_h    += int'(h !== 9'(eh));
            bad_v    += int'(v !== 9'(ev));
            bad_lhbl += int'(LHBL !== (eh < 384));
            bad_hs   += int'(HS !== (eh >= 416 && eh < 448));
            bad_lvbl += int'(LVBL !== 1'b0);
            bad_p2   += int'(pxl2_cen !== 1'b1);
            bad_p    += int'(pxl_cen !== (e % 2 == 0));
            if (e == 1025) begin
                check("wrap_h", h, 0);
                check("wrap_v", v, 1);
            end
        end
        check("line_pxl_cen_count", cnt, 512);
        check("line_h", bad_h, 0);
        check("line_v", bad_v, 0);
        check("line_LHBL", bad_lhbl, 0);
        check("line_HS", bad_hs, 0);
        check("line_LVBL", bad_lvbl, 0);
        check("fast_pxl2_cen", bad_p2, 0);
        check("fast_pxl_cen", bad_p, 0);

        // mid-line reset at h=200 acts without a clk edge
        check("pre_rst_h", h, 200);
        rst = 1'b1;
        #1;
        check_reset_default();
        first_scenario();

        // small frame: windows, flip latching, vint
        @(negedge clk);
        rst_s = 1'b0;
        {bad_h, bad_v, bad_lhbl, bad_lvbl, bad_hs, bad_vs} = '0;
        {bad_hf, bad_vf, bad_vint, vints} = '0;
        for (int e = 1; e <= 1400; e++) begin
            @(negedge clk);
            p   = (e - 1) / 2;
            eh5 = 5'(p % 16);
            ev5 = 5'((p / 16) % 20);
            fl  = (e >= 641) && (e < 1281);
            bad_h    += int'(h_s !== eh5);
            bad_v    += int'(v_s !== ev5);
            bad_lhbl += int'(LHBL_s !== (eh5 < 12));
            bad_hs   += int'(HS_s !== (eh5 >= 13 && eh5 < 15));
            bad_lvbl += int'(LVBL_s !== !(ev5 >= 16 || ev5 < 2));
            bad_vs   += int'(VS_s !== (ev5 >= 17 && ev5 < 19));
            bad_hf   += int'(hf_s !== (eh5 ^ {5{fl}}));
            bad_vf   += int'(vf_s !== (ev5 ^ {5{fl}}));
            bad_vint += int'(vint_s !== (e % 2 == 1 && p % 320 == 256));
            vints    += int'(vint_s);
            if (e == 513) check("vint_at_vb", {h_s, v_s}, {5'd0, 5'd16});
            if (e == 100) flip_s = 1'b1;
            if (e == 800) flip_s = 1'b0;
        end
        check("frame_h", bad_h, 0);
        check("frame_v", bad_v, 0);
        check("frame_LHBL", bad_lhbl, 0);
        check("frame_HS", bad_hs, 0);
        check("frame_LVBL", bad_lvbl, 0);
        check("frame_VS", bad_vs, 0);
        check("flip_hf", bad_hf, 0);
        check("flip_vf", bad_vf, 0);
        check("vint_timing", bad_vint, 0);
        check("vint_count", vints, 2);

        // mid-frame reset of the small instance
        check("pre_rst_s_v", v_s, 3);
        rst_s = 1'b1;
        #1;
        check("rst_s_h", h_s, 0);
        check("rst_s_v", v_s, 0);
        check("rst_s_hf", hf_s, 0);
        check("rst_s_vf", vf_s, 0);
        check("rst_s_LHBL", LHBL_s, 1);
        check("rst_s_LVBL", LVBL_s, 0);
        check("rst_s_HS", HS_s, 0);
        check("rst_s_VS", VS_s, 0);
        check("rst_s_vint", vint_s, 0);
        check("rst_s_pxl2_cen", pxl2_cen_s, 0);
        check("rst_s_pxl_cen", pxl_cen_s, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
